// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiply unit: command encodings,
// FSM state type and command decode helpers.
package mul_pkg;

  localparam logic [2:0] CMD_MUL   = 3'b000;
  localparam logic [2:0] CMD_MLA   = 3'b001;
  localparam logic [2:0] CMD_UMULL = 3'b100;
  localparam logic [2:0] CMD_UMLAL = 3'b101;
  localparam logic [2:0] CMD_SMULL = 3'b110;
  localparam logic [2:0] CMD_SMLAL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mul_state_t;

  function automatic logic is_long(input logic [2:0] cmd);
    return (cmd == CMD_UMULL) || (cmd == CMD_UMLAL) ||
           (cmd == CMD_SMULL) || (cmd == CMD_SMLAL);
  endfunction

  function automatic logic is_signed(input logic [2:0] cmd);
    return (cmd == CMD_SMULL) || (cmd == CMD_SMLAL);
  endfunction

  function automatic logic is_acc(input logic [2:0] cmd);
    return (cmd == CMD_MLA) || (cmd == CMD_UMLAL) || (cmd == CMD_SMLAL);
  endfunction

  // 010 and 011 are the only encodings outside the multiply family
  function automatic logic is_legal(input logic [2:0] cmd);
    return (cmd != 3'b010) && (cmd != 3'b011);
  endfunction

endpackage

// File: rtl/mul_if.sv
// Request/response bundle between the EXE stage and the multiply unit.
interface mul_if #(parameter int DATA_LEN = 32);
  logic                start;
  logic [2:0]          MUL_CMD;
  logic [DATA_LEN-1:0] Rm;
  logic [DATA_LEN-1:0] Rs;
  logic [DATA_LEN-1:0] Acc_Hi;
  logic [DATA_LEN-1:0] Acc_Lo;
  logic                busy;
  logic                done;
  logic [DATA_LEN-1:0] Res_Hi;
  logic [DATA_LEN-1:0] Res_Lo;
  logic                N;
  logic                Z;

  modport master (
    output start, MUL_CMD, Rm, Rs, Acc_Hi, Acc_Lo,
    input  busy, done, Res_Hi, Res_Lo, N, Z
  );

  modport slave (
    input  start, MUL_CMD, Rm, Rs, Acc_Hi, Acc_Lo,
    output busy, done, Res_Hi, Res_Lo, N, Z
  );
endinterface

// File: rtl/mul_step.sv
// One shift-and-add iteration: retires BITS_PER_CYCLE multiplier bits into
// the double-width partial sum.
module mul_step #(
  parameter int DATA_LEN       = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*DATA_LEN-1:0] psum_i,
  input  logic [2*DATA_LEN-1:0] mcand_i,
  input  logic [DATA_LEN-1:0]   mplier_i,
  output logic [2*DATA_LEN-1:0] psum_o,
  output logic [2*DATA_LEN-1:0] mcand_o,
  output logic [DATA_LEN-1:0]   mplier_o
);

  always_comb begin
    psum_o = psum_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_i[i]) psum_o = psum_o + (mcand_i << i);
    end
    mcand_o  = mcand_i << BITS_PER_CYCLE;
    mplier_o = mplier_i >> BITS_PER_CYCLE;
  end

endmodule

// File: rtl/mul_unit.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit with start/busy/done handshake.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module mul_unit
  import mul_pkg::*;
#(
  parameter int DATA_LEN       = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  mul_if.slave bus
);

  localparam int NSTEP = DATA_LEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam int PW    = 2 * DATA_LEN;

  mul_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       psum_q, psum_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [DATA_LEN-1:0] mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [2:0]          cmd_q, cmd_d;
  logic                neg_q, neg_d;
  logic [DATA_LEN-1:0] res_hi_q, res_hi_d;
  logic [DATA_LEN-1:0] res_lo_q, res_lo_d;
  logic                n_q, n_d;
  logic                z_q, z_d;

  logic [PW-1:0]       psum_nx, mcand_nx;
  logic [DATA_LEN-1:0] mplier_nx;
  logic                last_step;
  logic                cap_signed;
  logic [DATA_LEN-1:0] rm_mag, rs_mag;
  logic [PW-1:0]       prod, sum;

  mul_step #(
    .DATA_LEN       (DATA_LEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .psum_i   (psum_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .psum_o   (psum_nx),
    .mcand_o  (mcand_nx),
    .mplier_o (mplier_nx)
  );

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt_q == CW'(NSTEP - 1)) || (mplier_nx == '0);
`else
  assign last_step = (cnt_q == CW'(NSTEP - 1));
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (last_step) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  // Signed commands multiply magnitudes; 2^(DATA_LEN-1) is its own negation,
  // which read as unsigned is the exact magnitude of the most-negative value.
  always_comb begin
    cap_signed = is_signed(bus.MUL_CMD);
    rm_mag = (cap_signed && bus.Rm[DATA_LEN-1]) ? -bus.Rm : bus.Rm;
    rs_mag = (cap_signed && bus.Rs[DATA_LEN-1]) ? -bus.Rs : bus.Rs;
    prod   = neg_q ? -psum_q : psum_q;
    sum    = prod + acc_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    psum_d   = psum_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cmd_d    = cmd_q;
    neg_d    = neg_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    n_d      = n_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        cnt_d    = '0;
        psum_d   = '0;
        mcand_d  = {{DATA_LEN{1'b0}}, rm_mag};
        mplier_d = rs_mag;
        cmd_d    = bus.MUL_CMD;
        neg_d    = cap_signed && (bus.Rm[DATA_LEN-1] ^ bus.Rs[DATA_LEN-1]);
        if (!is_acc(bus.MUL_CMD))      acc_d = '0;
        else if (is_long(bus.MUL_CMD)) acc_d = {bus.Acc_Hi, bus.Acc_Lo};
        else                           acc_d = {{DATA_LEN{1'b0}}, bus.Acc_Lo};
      end
      S_CALC: begin
        cnt_d    = cnt_q + CW'(1);
        psum_d   = psum_nx;
        mcand_d  = mcand_nx;
        mplier_d = mplier_nx;
      end
      S_FIX: begin
        if (!is_legal(cmd_q)) begin
          res_hi_d = '0;
          res_lo_d = '0;
          n_d      = 1'b0;
          z_d      = 1'b1;
        end else if (is_long(cmd_q)) begin
          res_hi_d = sum[PW-1:DATA_LEN];
          res_lo_d = sum[DATA_LEN-1:0];
          n_d      = sum[PW-1];
          z_d      = (sum == '0);
        end else begin
          res_hi_d = '0;
          res_lo_d = sum[DATA_LEN-1:0];
          n_d      = sum[DATA_LEN-1];
          z_d      = (sum[DATA_LEN-1:0] == '0);
        end
      end
      default: ;
    endcase
  end

  // Control and architecturally visible results are reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  // Working datapath is always reloaded at capture, so it carries no reset
  always_ff @(posedge clk) begin
    psum_q   <= psum_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    cmd_q    <= cmd_d;
    neg_q    <= neg_d;
  end

  assign bus.Res_Hi = res_hi_q;
  assign bus.Res_Lo = res_lo_q;
  assign bus.N      = n_q;
  assign bus.Z      = z_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: a BITS_PER_CYCLE=1 instance and a BITS_PER_CYCLE=4 instance.
module tb_mul_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_if #(.DATA_LEN(32)) bus ();
  mul_if #(.DATA_LEN(32)) bus4 ();

  mul_unit #(.DATA_LEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mul_unit #(.DATA_LEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

`ifdef MUL_EARLY_TERM_EN
  localparam int LAT_RS0  = 3;
  localparam int LAT_RSFF = 10;
`else
  localparam int LAT_RS0  = 34;
  localparam int LAT_RSFF = 34;
`endif

  // Launches one operation on the selected instance and returns the cycle of done
  // (start sampled at edge 0), or -1 if done never arrives.
  task automatic run_op(input bit sel, input logic [2:0] cmd, input logic [31:0] rm,
                        input logic [31:0] rs, input logic [31:0] ahi,
                        input logic [31:0] alo, output int lat);
    @(posedge clk); #1;
    if (sel) begin
      bus4.MUL_CMD = cmd; bus4.Rm = rm; bus4.Rs = rs; bus4.Acc_Hi = ahi; bus4.Acc_Lo = alo;
      bus4.start = 1'b1;
    end else begin
      bus.MUL_CMD = cmd; bus.Rm = rm; bus.Rs = rs; bus.Acc_Hi = ahi; bus.Acc_Lo = alo;
      bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus4.start = 1'b0;
    bus.Rm = 32'hDEAD_BEEF; bus.Rs = 32'h1234_5678; bus.Acc_Hi = 32'h5A5A_5A5A; bus.Acc_Lo = 32'hA5A5_A5A5;
    bus4.Rm = 32'hDEAD_BEEF; bus4.Rs = 32'h1234_5678; bus4.Acc_Hi = 32'h5A5A_5A5A; bus4.Acc_Lo = 32'hA5A5_A5A5;
    bus.MUL_CMD = 3'b010; bus4.MUL_CMD = 3'b010;
    lat = 1;
    while (!(sel ? bus4.done : bus.done) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(sel ? bus4.done : bus.done)) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.Res_Hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.Res_Hi); end
    checks++; if (bus.Res_Lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.Res_Lo); end
    checks++; if ({bus.N, bus.Z} !== 2'b00) begin errors++; $display("FAIL reset_nz: got %b want 00", {bus.N, bus.Z}); end
    rst = 1'b0;
  endtask

  task automatic test_umull_max();
    int lat;
    run_op(1'b0, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL umull_lat: got %0d want 34", lat); end
    checks++; if (bus.Res_Hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umull_hi: got %h want fffffffe", bus.Res_Hi); end
    checks++; if (bus.Res_Lo !== 32'h0000_0001) begin errors++; $display("FAIL umull_lo: got %h want 00000001", bus.Res_Lo); end
    checks++; if ({bus.N, bus.Z} !== 2'b10) begin errors++; $display("FAIL umull_nz: got %b want 10", {bus.N, bus.Z}); end
    @(posedge clk); #1;
    checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL umull_after_done: got %b want 00", {bus.done, bus.busy}); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(1'b0, 3'b110, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0, lat);
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL smull_res: got %h%h want fffffffffffffffe", bus.Res_Hi, bus.Res_Lo); end
    checks++; if (bus.N !== 1'b1) begin errors++; $display("FAIL smull_n: got %b want 1", bus.N); end
    run_op(1'b0, 3'b111, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h1, lat);
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h4000_0000_0000_0001) begin errors++; $display("FAIL smlal_res: got %h%h want 4000000000000001", bus.Res_Hi, bus.Res_Lo); end
    checks++; if ({bus.N, bus.Z} !== 2'b00) begin errors++; $display("FAIL smlal_nz: got %b want 00", {bus.N, bus.Z}); end
  endtask

  task automatic test_short_and_acc();
    int lat;
    run_op(1'b0, 3'b001, 32'h3, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, lat);
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h0) begin errors++; $display("FAIL mla_res: got %h%h want 0", bus.Res_Hi, bus.Res_Lo); end
    checks++; if ({bus.N, bus.Z} !== 2'b01) begin errors++; $display("FAIL mla_nz: got %b want 01", {bus.N, bus.Z}); end
    run_op(1'b0, 3'b000, 32'h1234_5678, 32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h0000_0000_2345_6780) begin errors++; $display("FAIL mul_res: got %h%h want 0000000023456780", bus.Res_Hi, bus.Res_Lo); end
    run_op(1'b0, 3'b000, 32'h4000_0000, 32'h0000_0002, 32'h0, 32'h0, lat);
    checks++; if ({bus.Res_Lo, bus.N, bus.Z} !== {32'h8000_0000, 2'b10}) begin errors++; $display("FAIL mul_neg: got %h %b%b want 80000000 10", bus.Res_Lo, bus.N, bus.Z); end
    run_op(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1, 32'h1, lat);
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h0000_0002_FFFF_FFFF) begin errors++; $display("FAIL umlal_res: got %h%h want 00000002ffffffff", bus.Res_Hi, bus.Res_Lo); end
    run_op(1'b0, 3'b010, 32'h3, 32'h5, 32'h1, 32'h1, lat);
    checks++; if ({bus.Res_Hi, bus.Res_Lo, bus.N, bus.Z} !== {64'h0, 2'b01}) begin errors++; $display("FAIL illegal_res: got %h%h %b%b want 0 01", bus.Res_Hi, bus.Res_Lo, bus.N, bus.Z); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL illegal_lat: got %0d want 34", lat); end
  endtask

  task automatic test_start_while_busy();
    int cyc = 1;
    int pulses = 0;
    int first = 0;
    @(posedge clk); #1;
    bus.MUL_CMD = 3'b100; bus.Rm = 32'h6; bus.Rs = 32'h8000_0007; bus.Acc_Hi = 32'h0; bus.Acc_Lo = 32'h0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc <= 40) begin
      if (cyc == 5) begin bus.start = 1'b1; bus.Rm = 32'd100; end
      else bus.start = 1'b0;
      if (bus.done) begin pulses++; if (first == 0) first = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    checks++; if (first !== 34) begin errors++; $display("FAIL busy_start_lat: got %0d want 34", first); end
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h0000_0003_0000_002A) begin errors++; $display("FAIL busy_start_hold: got %h%h want 000000030000002a", bus.Res_Hi, bus.Res_Lo); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(posedge clk); #1;
    bus.MUL_CMD = 3'b100; bus.Rm = 32'h5; bus.Rs = 32'h8000_0001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.N, bus.Z} !== 4'b0000) begin errors++; $display("FAIL mid_rst_ctrl: got %b want 0000", {bus.busy, bus.done, bus.N, bus.Z}); end
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h0) begin errors++; $display("FAIL mid_rst_res: got %h%h want 0", bus.Res_Hi, bus.Res_Lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_rst_nodone: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_early_term();
    int lat;
    run_op(1'b0, 3'b100, 32'hABCD_1234, 32'h0, 32'h0, 32'h0, lat);
    checks++; if (lat !== LAT_RS0) begin errors++; $display("FAIL rs0_lat: got %0d want %0d", lat, LAT_RS0); end
    checks++; if ({bus.Res_Hi, bus.Res_Lo, bus.Z} !== {64'h0, 1'b1}) begin errors++; $display("FAIL rs0_res: got %h%h z=%b want 0 z=1", bus.Res_Hi, bus.Res_Lo, bus.Z); end
    run_op(1'b0, 3'b100, 32'h0000_0101, 32'h0000_00FF, 32'h0, 32'h0, lat);
    checks++; if (lat !== LAT_RSFF) begin errors++; $display("FAIL rsff_lat: got %0d want %0d", lat, LAT_RSFF); end
    checks++; if ({bus.Res_Hi, bus.Res_Lo} !== 64'h0000_0000_0000_FFFF) begin errors++; $display("FAIL rsff_res: got %h%h want 000000000000ffff", bus.Res_Hi, bus.Res_Lo); end
  endtask

  task automatic test_bpc4();
    int lat;
    run_op(1'b1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL bpc4_lat: got %0d want 10", lat); end
    checks++; if ({bus4.Res_Hi, bus4.Res_Lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL bpc4_umull: got %h%h want fffffffe00000001", bus4.Res_Hi, bus4.Res_Lo); end
    run_op(1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, lat);
    checks++; if ({bus4.Res_Hi, bus4.Res_Lo, bus4.N} !== {64'hC000_0000_8000_0000, 1'b1}) begin errors++; $display("FAIL bpc4_smull: got %h%h n=%b want c000000080000000 n=1", bus4.Res_Hi, bus4.Res_Lo, bus4.N); end
    run_op(1'b1, 3'b111, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0, 32'h15, lat);
    checks++; if ({bus4.Res_Hi, bus4.Res_Lo, bus4.Z} !== {64'h0, 1'b1}) begin errors++; $display("FAIL bpc4_smlal: got %h%h z=%b want 0 z=1", bus4.Res_Hi, bus4.Res_Lo, bus4.Z); end
  endtask

  initial begin
    bus.start = 1'b0; bus.MUL_CMD = 3'b000; bus.Rm = '0; bus.Rs = '0; bus.Acc_Hi = '0; bus.Acc_Lo = '0;
    bus4.start = 1'b0; bus4.MUL_CMD = 3'b000; bus4.Rm = '0; bus4.Rs = '0; bus4.Acc_Hi = '0; bus4.Acc_Lo = '0;
    test_reset();
    test_umull_max();
    test_signed();
    test_short_and_acc();
    test_start_while_busy();
    test_reset_mid();
    test_early_term();
    test_bpc4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Multi-cycle integer multiply / multiply-accumulate unit for the EXE stage, alongside the single-cycle ALU. Covers the ARM multiply family: MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. It is parametrised in operand width and in bits retired per cycle. A start/busy/done handshake lets the hazard unit stall the pipeline while a product is computed.

## Interface
- `DATA_LEN`, 32: operand width; results are `DATA_LEN` (short) or `2*DATA_LEN` (long) bits.
- `BITS_PER_CYCLE`, 1: multiplier bits retired per CALC cycle; legal values 1, 2, 4, and it must divide `DATA_LEN`. `NSTEP = DATA_LEN/BITS_PER_CYCLE`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `MUL_CMD` in 3: operation, encodings listed under Operation.
- `Rm` in DATA_LEN: multiplicand.
- `Rs` in DATA_LEN: multiplier.
- `Acc_Hi` in DATA_LEN: high accumulate word; used by UMLAL and SMLAL.
- `Acc_Lo` in DATA_LEN: low accumulate word; used by MLA, UMLAL and SMLAL.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse; results are valid from this cycle.
- `Res_Hi` out DATA_LEN: high result word; 0 for short operations.
- `Res_Lo` out DATA_LEN: low result word.
- `N` out 1: negative flag of the result.
- `Z` out 1: zero flag of the result.

## Operation
- Command encodings:
  - 000 MUL: Lo = (Rm·Rs) mod 2^DATA_LEN.
  - 001 MLA: Lo = (Rm·Rs + Acc_Lo) mod 2^DATA_LEN.
  - 100 UMULL: {Hi,Lo} = unsigned Rm·Rs.
  - 101 UMLAL: {Hi,Lo} = unsigned Rm·Rs + {Acc_Hi,Acc_Lo}.
  - 110 SMULL: {Hi,Lo} = signed Rm·Rs.
  - 111 SMLAL: {Hi,Lo} = signed Rm·Rs + {Acc_Hi,Acc_Lo}.
  - 010 and 011 are illegal. They take the normal path with results forced to 0 (Z=1, N=0).
- Operand capture: `MUL_CMD`, `Rm`, `Rs`, `Acc_Hi` and `Acc_Lo` are registered when `start` is accepted. Input changes after that point have no effect.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE → CALC on `start`. Operands are captured here.
  - CALC → FIX after `NSTEP` cycles.
  - FIX → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Signed commands:
  - CALC operates on magnitudes |Rm| and |Rs|. The sign `neg = Rm[msb] ^ Rs[msb]` is stored at capture.
  - In FIX the 2·DATA_LEN product is two's-complement negated if `neg` is set.
  - Most-negative operands are handled exactly: 0x8000_0000 · 0x8000_0000 = 2^62.
- Unsigned and short commands skip the negation.
- Accumulate is added in FIX, modulo 2^(2·DATA_LEN) for long commands and modulo 2^DATA_LEN for short ones.
- Each CALC step conditionally adds shifted multiplicand multiples into a 2·DATA_LEN partial sum and shifts the multiplier right by `BITS_PER_CYCLE`.
- Flags:
  - Long commands: N = Res_Hi[msb], Z = ({Res_Hi,Res_Lo} == 0).
  - Short commands: N = Res_Lo[msb], Z = (Res_Lo == 0).
  - No C or V output; the CPSR C and V bits are left to the caller.
- Results and flags hold their values until the next FIX updates them.
- `start` while busy is ignored: no queuing, no error.
- Reset, including mid-operation:
  - State returns to IDLE immediately.
  - `busy`, `done`, `Res_Hi`, `Res_Lo`, `N` and `Z` all go to 0.

## Timing
- `start` sampled at edge 0 → CALC occupies cycles 1..NSTEP, FIX is cycle NSTEP+1, DONE (`done`=1) is cycle NSTEP+2.
- DATA_LEN=32, BITS_PER_CYCLE=1: `done` at cycle 34. With BITS_PER_CYCLE=4: `done` at cycle 10.
- `busy` is high for cycles 1..NSTEP+2. A new `start` is accepted at the earliest in cycle NSTEP+3.
- No combinational path from any input to any output.

## Configuration
- `MUL_EARLY_TERM_EN` defined: at the end of each CALC cycle, if the remaining multiplier bits are all zero, the next state is FIX.
  - Minimum latency is 3 cycles (Rs=0 gives `done` at cycle 3).
  - Latency is data-dependent: Rs=0x0000_00FF with BITS_PER_CYCLE=1 gives `done` at cycle 10.
- `MUL_EARLY_TERM_EN` undefined: latency is fixed at NSTEP+2 for every operand.
- Results are identical with and without the macro.

## Structure
- Package `mul_pkg`: MUL_CMD encoding constants, FSM state typedef, and the `is_long` / `is_signed` / `is_acc` decode helpers.
- Sub-module `mul_step`: a combinational step that retires `BITS_PER_CYCLE` bits (partial sum, multiplicand, multiplier in; updated values out). It is instantiated once in CALC.

## Test plan
- UMULL 0xFFFFFFFF·0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001, N=1, Z=0, `done` at cycle 34 (macro off).
- SMULL 0xFFFFFFFF·0x00000002 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFE, N=1.
- MLA Rm=3, Rs=5, Acc_Lo=0xFFFFFFF1 → Lo=0, Hi=0, Z=1, N=0.
- SMLAL Rm=Rs=0x80000000, Acc={0,1} → Hi=0x40000000, Lo=0x00000001, N=0.
- `start` pulsed at cycle 5 of a running op → ignored, single `done` pulse. `rst` asserted at cycle 10 of a running op → busy=0, results 0, no `done`.
- UMULL Rs=0: `done` at cycle 3 with `MUL_EARLY_TERM_EN`, at cycle 34 without; both give Hi=Lo=0, Z=1.
